// File: rtl/ftdi_bridge_pkg.sv
// rtl/ftdi_bridge_pkg.sv - shared states, register offsets and status bit positions for ftdi_bridge
package ftdi_bridge_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_STAT,
    ST_WAIT_RDY,
    ST_RD_STB,
    ST_WR_SETUP,
    ST_WR_STB,
    ST_WR_HOLD,
    ST_ACK,
    ST_RECOVER,
    ST_ABORT
  } state_e;

  localparam logic REG_DATA = 1'b0;
  localparam logic REG_STAT = 1'b1;

  localparam int STAT_RXF = 0;
  localparam int STAT_TXE = 1;
  localparam int STAT_TMO = 7;

  // Bit positions inside the synchronised bundle {cs, as_n, uds_n, rw, rxf_n, txe_n}
  localparam int SY_CS    = 5;
  localparam int SY_AS_N  = 4;
  localparam int SY_UDS_N = 3;
  localparam int SY_RW    = 2;
  localparam int SY_RXF_N = 1;
  localparam int SY_TXE_N = 0;
  localparam logic [5:0] SY_INACTIVE = 6'b011111;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ftdi_bridge_sync2.sv
// rtl/ftdi_bridge_sync2.sv - two-flop synchronizer, resets to the inactive level of each bit
module ftdi_bridge_sync2 #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ftdi_bridge.sv
// rtl/ftdi_bridge.sv - 68000 byte cycle to FT245 RD#/WR# strobe bridge with DTACK# generation
// FTDI_TIMEOUT_EN adds the WAIT_RDY timeout, BERR# abort and sticky timeout flag.
module ftdi_bridge
  import ftdi_bridge_pkg::*;
#(
  parameter int RD_PULSE = 4,
  parameter int WR_PULSE = 4,
  parameter int RECOVERY = 3,
  parameter int TIMEOUT  = 1024
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       ftdi_cs,
  input  logic       as_n,
  input  logic       uds_n,
  input  logic       rw,
  input  logic       a1,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       cpu_doe,
  output logic       dtack_n,
  output logic       berr_n,
  input  logic       ftdi_rxf_n,
  input  logic       ftdi_txe_n,
  output logic       ftdi_rd_n,
  output logic       ftdi_wr,
  input  logic [7:0] ftdi_din,
  output logic [7:0] ftdi_dout,
  output logic       ftdi_doe,
  output logic       busy
);

`ifdef FTDI_TIMEOUT_EN
  localparam int CNT_MAX = max_of(max_of(RD_PULSE, WR_PULSE), max_of(RECOVERY, TIMEOUT));
`else
  localparam int CNT_MAX = max_of(max_of(RD_PULSE, WR_PULSE), RECOVERY);
`endif
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(RD_PULSE - 1);
  localparam logic [CW-1:0] WR_LAST  = CW'(WR_PULSE - 1);
  localparam logic [CW-1:0] REC_LAST = CW'(RECOVERY - 1);

  logic [5:0] sy;
  logic       start;
  logic [7:0] status;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          rw_q;
  logic          stat_q;
  logic          rd_n_q;
  logic          wr_q;
  logic          fdoe_q;
  logic [7:0]    fdout_q;
  logic          dtack_n_q;
  logic          cdoe_q;
  logic [7:0]    cdout_q;

  ftdi_bridge_sync2 #(
    .W       (6),
    .RST_VAL (SY_INACTIVE)
  ) u_sync (
    .clk_i (sysclk),
    .rst_i (rst),
    .d_i   ({ftdi_cs, as_n, uds_n, rw, ftdi_rxf_n, ftdi_txe_n}),
    .q_o   (sy)
  );

  assign start = sy[SY_CS] & ~sy[SY_AS_N] & ~sy[SY_UDS_N];

`ifdef FTDI_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  logic berr_n_q;
  logic tmo_q;
  assign berr_n = berr_n_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign berr_n = 1'b1;
`endif

  always_comb begin
    status           = 8'h00;
    status[STAT_RXF] = ~sy[SY_RXF_N];
    status[STAT_TXE] = ~sy[SY_TXE_N];
`ifdef FTDI_TIMEOUT_EN
    status[STAT_TMO] = tmo_q;
`endif
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rw_q      <= 1'b1;
      stat_q    <= 1'b0;
      rd_n_q    <= 1'b1;
      wr_q      <= 1'b0;
      fdoe_q    <= 1'b0;
      fdout_q   <= 8'h00;
      dtack_n_q <= 1'b1;
      cdoe_q    <= 1'b0;
      cdout_q   <= 8'h00;
`ifdef FTDI_TIMEOUT_EN
      berr_n_q  <= 1'b1;
      tmo_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rw_q    <= sy[SY_RW];
            stat_q  <= (a1 == REG_STAT);
            cnt_q   <= '0;
            state_q <= (a1 == REG_STAT) ? ST_STAT : ST_WAIT_RDY;
          end
        end
        ST_STAT: begin
          if (rw_q) begin
            cdout_q <= status;
            cdoe_q  <= 1'b1;
          end
`ifdef FTDI_TIMEOUT_EN
          else if (cpu_din[STAT_TMO]) begin
            tmo_q <= 1'b0;
          end
`endif
          dtack_n_q <= 1'b0;
          state_q   <= ST_ACK;
        end
        ST_WAIT_RDY: begin
          // CPU gave up before any strobe started: drop the cycle silently
          if (sy[SY_AS_N]) begin
            state_q <= ST_IDLE;
          end else if (rw_q && !sy[SY_RXF_N]) begin
            rd_n_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_RD_STB;
          end else if (!rw_q && !sy[SY_TXE_N]) begin
            fdout_q <= cpu_din;
            fdoe_q  <= 1'b1;
            state_q <= ST_WR_SETUP;
          end
`ifdef FTDI_TIMEOUT_EN
          else if (cnt_q == TMO_LAST) begin
            berr_n_q <= 1'b0;
            tmo_q    <= 1'b1;
            state_q  <= ST_ABORT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        ST_RD_STB: begin
          if (cnt_q == RD_LAST) begin
            cdout_q   <= ftdi_din;
            cdoe_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            dtack_n_q <= 1'b0;
            state_q   <= ST_ACK;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WR_SETUP: begin
          wr_q    <= 1'b1;
          cnt_q   <= '0;
          state_q <= ST_WR_STB;
        end
        ST_WR_STB: begin
          if (cnt_q == WR_LAST) begin
            wr_q    <= 1'b0;
            state_q <= ST_WR_HOLD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WR_HOLD: begin
          fdoe_q    <= 1'b0;
          dtack_n_q <= 1'b0;
          state_q   <= ST_ACK;
        end
        ST_ACK: begin
          if (sy[SY_AS_N]) begin
            dtack_n_q <= 1'b1;
            cdoe_q    <= 1'b0;
            cnt_q     <= '0;
            state_q   <= stat_q ? ST_IDLE : ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          if (cnt_q == REC_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef FTDI_TIMEOUT_EN
        ST_ABORT: begin
          if (sy[SY_AS_N]) begin
            berr_n_q <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cpu_dout  = cdout_q;
  assign cpu_doe   = cdoe_q;
  assign dtack_n   = dtack_n_q;
  assign ftdi_rd_n = rd_n_q;
  assign ftdi_wr   = wr_q;
  assign ftdi_dout = fdout_q;
  assign ftdi_doe  = fdoe_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ftdi_bridge.sv
// tb/tb_ftdi_bridge.sv - scoreboard bench for ftdi_bridge: directed bus cycles, monitor-side checking
module tb_ftdi_bridge;

  localparam int RD_PULSE = 4;
  localparam int WR_PULSE = 4;
  localparam int RECOVERY = 3;
  localparam int TIMEOUT  = 16;
`ifdef FTDI_TIMEOUT_EN
  localparam int TXE_WAIT = 10;
`else
  localparam int TXE_WAIT = 20;
`endif

  logic       sysclk = 1'b0;
  logic       rst;
  logic       ftdi_cs, as_n, uds_n, rw, a1;
  logic [7:0] cpu_din, cpu_dout;
  logic       cpu_doe, dtack_n, berr_n;
  logic       ftdi_rxf_n, ftdi_txe_n, ftdi_rd_n, ftdi_wr, ftdi_doe, busy;
  logic [7:0] ftdi_din, ftdi_dout;

  ftdi_bridge #(
    .RD_PULSE (RD_PULSE),
    .WR_PULSE (WR_PULSE),
    .RECOVERY (RECOVERY),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .ftdi_cs    (ftdi_cs),
    .as_n       (as_n),
    .uds_n      (uds_n),
    .rw         (rw),
    .a1         (a1),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .cpu_doe    (cpu_doe),
    .dtack_n    (dtack_n),
    .berr_n     (berr_n),
    .ftdi_rxf_n (ftdi_rxf_n),
    .ftdi_txe_n (ftdi_txe_n),
    .ftdi_rd_n  (ftdi_rd_n),
    .ftdi_wr    (ftdi_wr),
    .ftdi_din   (ftdi_din),
    .ftdi_dout  (ftdi_dout),
    .ftdi_doe   (ftdi_doe),
    .busy       (busy)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  typedef struct {
    int         due;
    bit         rd;
    logic [7:0] data;
    int         id;
  } exp_t;

  exp_t sb[$];
  int   op_id = 0;

  task automatic expect_ack(input int due, input bit rd, input logic [7:0] data);
    exp_t e;
    e.due  = due;
    e.rd   = rd;
    e.data = data;
    e.id   = op_id;
    op_id++;
    sb.push_back(e);
  endtask

  // Monitor: scoreboard on DTACK# falling, plus strobe/bus trackers
  int         n_dtack = 0;
  int         rd_run = 0, rd_last = 0, rd_pulses = 0;
  int         wr_run = 0, wr_last = 0, wr_pulses = 0, wr_rise = 0, wr_fall = 0;
  int         doe_rise = 0, doe_fall = 0, dout_bad = 0;
  logic [7:0] exp_wdata = 8'h00;

  initial begin : monitor
    exp_t e;
    logic dtack_prev = 1'b1;
    logic wr_prev = 1'b0;
    logic doe_prev = 1'b0;
    forever begin
      @(negedge sysclk);
      if (dtack_prev && !dtack_n) begin
        n_dtack++;
        if (sb.size() == 0) begin
          check("unexpected_dtack", cyc, -1);
        end else begin
          e = sb.pop_front();
          check($sformatf("op%0d_latency", e.id), cyc, e.due);
          check($sformatf("op%0d_cpu_doe", e.id), int'(cpu_doe), int'(e.rd));
          if (e.rd) check($sformatf("op%0d_cpu_dout", e.id), int'(cpu_dout), int'(e.data));
        end
      end
      dtack_prev = dtack_n;
      if (!ftdi_rd_n) rd_run++;
      else if (rd_run != 0) begin rd_last = rd_run; rd_run = 0; rd_pulses++; end
      if (ftdi_wr) begin
        if (!wr_prev) wr_rise = cyc;
        wr_run++;
      end else if (wr_prev) begin
        wr_fall = cyc; wr_last = wr_run; wr_run = 0; wr_pulses++;
      end
      wr_prev = ftdi_wr;
      if (ftdi_doe) begin
        if (!doe_prev) doe_rise = cyc;
        if (ftdi_dout !== exp_wdata) dout_bad++;
      end else if (doe_prev) doe_fall = cyc;
      doe_prev = ftdi_doe;
    end
  end

  task automatic drive_start(input logic r, input logic addr1, input logic [7:0] d);
    ftdi_cs = 1'b1; as_n = 1'b0; uds_n = 1'b0; rw = r; a1 = addr1; cpu_din = d;
  endtask

  task automatic bus_start(input logic r, input logic addr1, input logic [7:0] d);
    @(posedge sysclk); #1;
    drive_start(r, addr1, d);
  endtask

  task automatic wait_dtack(input logic lvl, input int budget, input string name);
    int n = 0;
    while (dtack_n !== lvl && n < budget) begin
      @(negedge sysclk);
      n++;
    end
    if (dtack_n !== lvl) check(name, int'(dtack_n), int'(lvl));
  endtask

  task automatic bus_release(input string name);
    @(posedge sysclk); #1;
    ftdi_cs = 1'b0; as_n = 1'b1; uds_n = 1'b1;
    wait_dtack(1'b1, 20, name);
  endtask

  task automatic settle;
    repeat (4) @(posedge sysclk);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 10000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int rd0, wr0, dt0, n, c0;
    rst = 1'b1; ftdi_cs = 1'b0; as_n = 1'b1; uds_n = 1'b1; rw = 1'b1; a1 = 1'b0;
    cpu_din = 8'h00; ftdi_rxf_n = 1'b1; ftdi_txe_n = 1'b1; ftdi_din = 8'h00;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    check("rst_rd_n", int'(ftdi_rd_n), 1);
    check("rst_wr", int'(ftdi_wr), 0);
    check("rst_ftdi_doe", int'(ftdi_doe), 0);
    check("rst_dtack_n", int'(dtack_n), 1);
    check("rst_berr_n", int'(berr_n), 1);
    check("rst_cpu_doe", int'(cpu_doe), 0);
    check("rst_cpu_dout", int'(cpu_dout), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge sysclk); #1 rst = 1'b0;

    // Status read: rxf ready, txe not ready
    ftdi_rxf_n = 1'b0; ftdi_txe_n = 1'b1;
    settle();
    rd0 = rd_pulses;
    bus_start(1'b1, 1'b1, 8'h00);
    expect_ack(cyc + 4, 1'b1, 8'h01);
    wait_dtack(1'b0, 20, "stat_rd_dtack_timeout");
    bus_release("stat_rd_release_timeout");
    check("stat_no_rd_strobe", rd_pulses, rd0);
    check("stat_idle_after_release", int'(busy), 0);

    // Status read: txe ready, rxf not ready
    ftdi_rxf_n = 1'b1; ftdi_txe_n = 1'b0;
    settle();
    bus_start(1'b1, 1'b1, 8'h00);
    expect_ack(cyc + 4, 1'b1, 8'h02);
    wait_dtack(1'b0, 20, "stat2_dtack_timeout");
    bus_release("stat2_release_timeout");

    // Data read 0xA5, then measure recovery
    ftdi_rxf_n = 1'b0; ftdi_txe_n = 1'b1; ftdi_din = 8'hA5;
    settle();
    rd0 = rd_pulses;
    bus_start(1'b1, 1'b0, 8'h00);
    expect_ack(cyc + 8, 1'b1, 8'hA5);
    wait_dtack(1'b0, 30, "rd_a5_dtack_timeout");
    bus_release("rd_a5_release_timeout");
    n = 0;
    while (busy && n < 20) begin n++; @(negedge sysclk); end
    check("rd_a5_rd_low_cycles", rd_last, RD_PULSE);
    check("rd_a5_rd_pulse_count", rd_pulses, rd0 + 1);
    check("rd_a5_recover_cycles", n, RECOVERY);

    // Data read 0x5A, then a read started during RECOVER waits for IDLE
    ftdi_din = 8'h5A;
    settle();
    bus_start(1'b1, 1'b0, 8'h00);
    expect_ack(cyc + 8, 1'b1, 8'h5A);
    wait_dtack(1'b0, 30, "rd_5a_dtack_timeout");
    bus_release("rd_5a_release_timeout");
    ftdi_din = 8'hC3;
    drive_start(1'b1, 1'b0, 8'h00);
    expect_ack(cyc + 9, 1'b1, 8'hC3);
    wait_dtack(1'b0, 30, "rd_c3_dtack_timeout");
    bus_release("rd_c3_release_timeout");

    // Data write 0x96 with the FIFO already accepting
    ftdi_rxf_n = 1'b1; ftdi_txe_n = 1'b0; exp_wdata = 8'h96;
    settle();
    wr0 = wr_pulses; rd0 = rd_pulses;
    bus_start(1'b0, 1'b0, 8'h96);
    expect_ack(cyc + 10, 1'b0, 8'h00);
    wait_dtack(1'b0, 30, "wr_96_dtack_timeout");
    bus_release("wr_96_release_timeout");
    check("wr_96_wr_high_cycles", wr_last, WR_PULSE);
    check("wr_96_wr_pulse_count", wr_pulses, wr0 + 1);
    check("wr_96_doe_setup", doe_rise, wr_rise - 1);
    check("wr_96_doe_hold", doe_fall, wr_fall + 1);
    check("wr_96_no_rd_strobe", rd_pulses, rd0);

    // Data write 0x3C held off by TXE# high
    ftdi_txe_n = 1'b1; exp_wdata = 8'h3C;
    settle();
    wr0 = wr_pulses;
    bus_start(1'b0, 1'b0, 8'h3C);
    repeat (TXE_WAIT) @(posedge sysclk);
    #1 ftdi_txe_n = 1'b0;
    check("wr_3c_no_wr_while_full", wr_pulses + int'(ftdi_wr), wr0);
    expect_ack(cyc + 9, 1'b0, 8'h00);
    wait_dtack(1'b0, 30, "wr_3c_dtack_timeout");
    bus_release("wr_3c_release_timeout");
    check("wr_3c_wr_high_cycles", wr_last, WR_PULSE);
    check("wr_3c_doe_setup", doe_rise, wr_rise - 1);
    check("wr_3c_doe_hold", doe_fall, wr_fall + 1);
    check("wr_ftdi_dout_stable", dout_bad, 0);

    // CPU abort while waiting for RXF#
    ftdi_rxf_n = 1'b1; ftdi_txe_n = 1'b1;
    settle();
    rd0 = rd_pulses; dt0 = n_dtack;
    bus_start(1'b1, 1'b0, 8'h00);
    repeat (10) @(posedge sysclk);
    #1 ftdi_cs = 1'b0; as_n = 1'b1; uds_n = 1'b1;
    repeat (8) @(posedge sysclk);
    @(negedge sysclk);
    check("abort_busy", int'(busy), 0);
    check("abort_no_rd_strobe", rd_pulses, rd0);
    check("abort_no_dtack", n_dtack, dt0);

    // Read stalled on RXF#: BERR# only when the timeout is built
    dt0 = n_dtack;
    bus_start(1'b1, 1'b0, 8'h00);
    c0 = cyc;
    n = 0;
    while (berr_n && n < 40) begin @(negedge sysclk); n++; end
`ifdef FTDI_TIMEOUT_EN
    check("tmo_berr_asserted", int'(berr_n), 0);
    check("tmo_berr_cycle", cyc, c0 + 3 + TIMEOUT);
`else
    check("no_tmo_berr_high", int'(berr_n), 1);
    check("no_tmo_still_waiting", int'(busy), 1);
`endif
    @(posedge sysclk); #1 ftdi_cs = 1'b0; as_n = 1'b1; uds_n = 1'b1;
    n = 0;
    while ((!berr_n || busy) && n < 10) begin @(negedge sysclk); n++; end
    check("stall_berr_released", int'(berr_n), 1);
    check("stall_no_dtack", n_dtack, dt0);
    settle();
`ifdef FTDI_TIMEOUT_EN
    bus_start(1'b1, 1'b1, 8'h00);
    expect_ack(cyc + 4, 1'b1, 8'h80);
    wait_dtack(1'b0, 20, "tmo_stat_dtack_timeout");
    bus_release("tmo_stat_release_timeout");
    bus_start(1'b0, 1'b1, 8'h80);
    expect_ack(cyc + 4, 1'b0, 8'h00);
    wait_dtack(1'b0, 20, "tmo_clr_dtack_timeout");
    bus_release("tmo_clr_release_timeout");
`endif
    bus_start(1'b1, 1'b1, 8'h00);
    expect_ack(cyc + 4, 1'b1, 8'h00);
    wait_dtack(1'b0, 20, "stat_clean_dtack_timeout");
    bus_release("stat_clean_release_timeout");

    // Reset in the middle of an RD# strobe
    ftdi_rxf_n = 1'b0; ftdi_din = 8'h77;
    settle();
    bus_start(1'b1, 1'b0, 8'h00);
    n = 0;
    while (ftdi_rd_n && n < 20) begin @(negedge sysclk); n++; end
    check("midrd_strobe_started", int'(ftdi_rd_n), 0);
    @(negedge sysclk);
    rst = 1'b1;
    @(negedge sysclk);
    check("midrd_rst_rd_n", int'(ftdi_rd_n), 1);
    check("midrd_rst_dtack_n", int'(dtack_n), 1);
    check("midrd_rst_cpu_doe", int'(cpu_doe), 0);
    check("midrd_rst_busy", int'(busy), 0);
    ftdi_cs = 1'b0; as_n = 1'b1; uds_n = 1'b1;
    @(posedge sysclk); #1 rst = 1'b0;
    repeat (6) @(posedge sysclk);
    @(negedge sysclk);
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
